// File: rtl/store_merge_buffer.sv
// Two-level store buffer between the store unit and the D$ write port.
// Speculative queue holds translated stores until commit. The commit queue holds
// retired stores, optionally byte-merges same-doubleword stores into its tail, and
// issues them to memory with up to MAX_OUTSTANDING writes in flight.
module store_merge_buffer #(
    parameter int SPEC_DEPTH      = 4,
    parameter int COMMIT_DEPTH    = 8,
    parameter int MAX_OUTSTANDING = 2,
    parameter int MERGE_EN        = 1,
    parameter int PLEN            = 56,
    parameter int XLEN            = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [PLEN-1:0]     paddr_i,
    input  logic [XLEN-1:0]     data_i,
    input  logic [XLEN/8-1:0]   be_i,
    input  logic                commit_i,
    output logic                commit_ready_o,
    input  logic [11:0]         page_offset_i,
    output logic                page_offset_matches_o,
    output logic                no_st_pending_o,
    output logic                empty_o,
    output logic                mem_req_o,
    output logic [PLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_data_o,
    output logic [XLEN/8-1:0]   mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_ack_i
);
    localparam int BEW = XLEN / 8;
    localparam int SPW = (SPEC_DEPTH > 1) ? $clog2(SPEC_DEPTH) : 1;
    localparam int CPW = (COMMIT_DEPTH > 1) ? $clog2(COMMIT_DEPTH) : 1;
    localparam int SCW = $clog2(SPEC_DEPTH + 1);
    localparam int CCW = $clog2(COMMIT_DEPTH + 1);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [PLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [BEW-1:0]  be;
    } entry_t;

    entry_t           r_spec [SPEC_DEPTH];
    logic [SPW-1:0]   r_spec_head, r_spec_tail;
    logic [SCW-1:0]   r_spec_cnt;
    entry_t           r_cq [COMMIT_DEPTH];
    logic [CPW-1:0]   r_cq_head, r_cq_tail;
    logic [CCW-1:0]   r_cq_cnt;
    logic [OW-1:0]    r_out;

    entry_t           w_spec_head_e, w_cq_tail_e, w_cq_head_e, w_merged, w_new_e;
    logic [SPW-1:0]   w_spec_head_nxt, w_spec_tail_nxt;
    logic [CPW-1:0]   w_cq_head_nxt, w_cq_tail_nxt, w_cq_last;
    logic             w_push, w_commit, w_merge_ok, w_append, w_gnt, w_ack;
    logic             w_match;
    logic             w_unused;

    assign w_unused = ^page_offset_i[2:0];

    assign w_new_e         = '{addr: paddr_i, data: data_i, be: be_i};
    assign w_spec_head_e   = r_spec[r_spec_head];
    assign w_cq_head_e     = r_cq[r_cq_head];
    assign w_cq_last       = (r_cq_tail == '0) ? CPW'(COMMIT_DEPTH - 1) : r_cq_tail - 1'b1;
    assign w_cq_tail_e     = r_cq[w_cq_last];

    assign w_spec_head_nxt = (r_spec_head == SPW'(SPEC_DEPTH - 1)) ? '0 : r_spec_head + 1'b1;
    assign w_spec_tail_nxt = (r_spec_tail == SPW'(SPEC_DEPTH - 1)) ? '0 : r_spec_tail + 1'b1;
    assign w_cq_head_nxt   = (r_cq_head == CPW'(COMMIT_DEPTH - 1)) ? '0 : r_cq_head + 1'b1;
    assign w_cq_tail_nxt   = (r_cq_tail == CPW'(COMMIT_DEPTH - 1)) ? '0 : r_cq_tail + 1'b1;

    // Readiness only looks at registered counts so a same-cycle commit never frees a slot.
    assign ready_o   = (r_spec_cnt < SCW'(SPEC_DEPTH));
    assign mem_req_o = (r_cq_cnt != '0) && (r_out < OW'(MAX_OUTSTANDING));

    // Never merge into a single entry that is being offered to memory right now.
    assign w_merge_ok = (MERGE_EN != 0) && (r_cq_cnt != '0)
                      && (w_spec_head_e.addr[PLEN-1:3] == w_cq_tail_e.addr[PLEN-1:3])
                      && !((r_cq_cnt == CCW'(1)) && mem_req_o);

    assign commit_ready_o = (r_spec_cnt != '0)
                          && ((r_cq_cnt < CCW'(COMMIT_DEPTH)) || w_merge_ok);

    assign w_push   = valid_i && ready_o && !flush_i;
    assign w_commit = commit_i && commit_ready_o;
    assign w_append = w_commit && !w_merge_ok;
    assign w_gnt    = mem_req_o && mem_gnt_i;
    assign w_ack    = mem_ack_i && (r_out != '0);

    assign mem_addr_o = w_cq_head_e.addr;
    assign mem_data_o = w_cq_head_e.data;
    assign mem_be_o   = w_cq_head_e.be;

    assign no_st_pending_o = (r_cq_cnt == '0) && (r_out == '0);
    assign empty_o         = no_st_pending_o && (r_spec_cnt == '0);
    assign page_offset_matches_o = w_match;

    // Merged tail: incoming bytes overwrite, byte enables accumulate.
    always_comb begin
        w_merged    = w_cq_tail_e;
        for (int b = 0; b < BEW; b++) begin
            if (w_spec_head_e.be[b]) w_merged.data[8*b +: 8] = w_spec_head_e.data[8*b +: 8];
        end
        w_merged.be = w_cq_tail_e.be | w_spec_head_e.be;
    end

    // Alias check over live slots of both queues plus the store arriving this cycle.
    always_comb begin
        int k;
        k       = 0;
        w_match = valid_i && (paddr_i[11:3] == page_offset_i[11:3]);
        for (int i = 0; i < SPEC_DEPTH; i++) begin
            k = i - int'(r_spec_head);
            if (k < 0) k = k + SPEC_DEPTH;
            if ((k < int'(r_spec_cnt)) && (r_spec[i].addr[11:3] == page_offset_i[11:3]))
                w_match = 1'b1;
        end
        for (int i = 0; i < COMMIT_DEPTH; i++) begin
            k = i - int'(r_cq_head);
            if (k < 0) k = k + COMMIT_DEPTH;
            if ((k < int'(r_cq_cnt)) && (r_cq[i].addr[11:3] == page_offset_i[11:3]))
                w_match = 1'b1;
        end
    end

    // Speculative queue storage.
    always_ff @(posedge clk_i) begin
        if (w_push) r_spec[r_spec_tail] <= w_new_e;
    end

    // Speculative queue pointers; flush drops everything left after this cycle's commit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_spec_head <= '0;
            r_spec_tail <= '0;
            r_spec_cnt  <= '0;
        end else begin
            if (w_push) r_spec_tail <= w_spec_tail_nxt;
            if (flush_i) begin
                r_spec_head <= r_spec_tail;
                r_spec_cnt  <= '0;
            end else begin
                if (w_commit) r_spec_head <= w_spec_head_nxt;
                r_spec_cnt <= r_spec_cnt + SCW'(w_push) - SCW'(w_commit);
            end
        end
    end

    // Commit queue storage: append a new entry or merge into the tail.
    always_ff @(posedge clk_i) begin
        if (w_append)      r_cq[r_cq_tail] <= w_spec_head_e;
        else if (w_commit) r_cq[w_cq_last] <= w_merged;
    end

    // Commit queue pointers and outstanding-write count; untouched by flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cq_head <= '0;
            r_cq_tail <= '0;
            r_cq_cnt  <= '0;
            r_out     <= '0;
        end else begin
            if (w_append) r_cq_tail <= w_cq_tail_nxt;
            if (w_gnt)    r_cq_head <= w_cq_head_nxt;
            r_cq_cnt <= r_cq_cnt + CCW'(w_append) - CCW'(w_gnt);
            r_out    <= r_out + OW'(w_gnt) - OW'(w_ack);
        end
    end

    // Protocol checks: commit only when ready, ack only with a write in flight.
    a_commit_ready: assert property (@(posedge clk_i) disable iff (rst_i)
                                     commit_i |-> commit_ready_o);
    a_ack_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
                                        mem_ack_i |-> (r_out != '0));
endmodule

// File: tb/tb_store_merge_buffer.sv
// Directed bench: one merging instance (defaults) and one non-merging instance.
module tb_store_merge_buffer;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, n_rst, flush, valid, commit;
    logic [55:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [11:0] poff;
    logic        gnt, ack, n_gnt, n_ack;

    logic        ready, commit_ready, match, no_st, empty, req;
    logic [55:0] maddr;
    logic [63:0] mdata;
    logic [7:0]  mbe;
    logic        n_ready, n_commit_ready, n_match, n_no_st, n_empty, n_req;
    logic [55:0] n_maddr;
    logic [63:0] n_mdata;
    logic [7:0]  n_mbe;

    int checks = 0;
    int errors = 0;

    store_merge_buffer u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(ready),
        .paddr_i(paddr), .data_i(data), .be_i(be), .commit_i(commit),
        .commit_ready_o(commit_ready), .page_offset_i(poff),
        .page_offset_matches_o(match), .no_st_pending_o(no_st), .empty_o(empty),
        .mem_req_o(req), .mem_addr_o(maddr), .mem_data_o(mdata), .mem_be_o(mbe),
        .mem_gnt_i(gnt), .mem_ack_i(ack)
    );

    store_merge_buffer #(.MERGE_EN(0)) u_nm (
        .clk_i(clk), .rst_i(n_rst), .flush_i(flush), .valid_i(valid), .ready_o(n_ready),
        .paddr_i(paddr), .data_i(data), .be_i(be), .commit_i(commit),
        .commit_ready_o(n_commit_ready), .page_offset_i(poff),
        .page_offset_matches_o(n_match), .no_st_pending_o(n_no_st), .empty_o(n_empty),
        .mem_req_o(n_req), .mem_addr_o(n_maddr), .mem_data_o(n_mdata), .mem_be_o(n_mbe),
        .mem_gnt_i(n_gnt), .mem_ack_i(n_ack)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [55:0] a, input logic [63:0] d, input logic [7:0] b);
        valid = 1'b1; paddr = a; data = d; be = b;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; n_rst = 1'b1; flush = 0; valid = 0; commit = 0;
        paddr = '0; data = '0; be = '0; poff = '0;
        gnt = 0; ack = 0; n_gnt = 0; n_ack = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        // reset state
        chk("rst_ready", ready, 1);
        chk("rst_commit_ready", commit_ready, 0);
        chk("rst_no_st", no_st, 1);
        chk("rst_empty", empty, 1);
        chk("rst_req", req, 0);
        chk("rst_match", match, 0);

        // 1: fill speculative queue
        push(56'h2000, 64'h1, 8'hFF);
        push(56'h2008, 64'h2, 8'hFF);
        push(56'h2010, 64'h3, 8'hFF);
        valid = 1'b1; paddr = 56'h2018; #1;
        chk("t1_ready_3", ready, 1);
        tick();
        chk("t1_ready_full", ready, 0);
        paddr = 56'h2020;
        tick();
        valid = 1'b0; #1;
        chk("t1_5th_dropped", u_dut.r_spec_cnt, 4);
        commit = 1'b1; #1;
        chk("t1_commit_ready", commit_ready, 1);
        tick();
        commit = 1'b0; #1;
        chk("t1_ready_after_commit", ready, 1);
        chk("t1_head_addr", maddr, 56'h2000);
        chk("t1_req", req, 1);
        flush = 1'b1; tick(); flush = 1'b0; #1;
        chk("t1_flush_spec", u_dut.r_spec_cnt, 0);
        gnt = 1'b1; tick(); gnt = 1'b0; #1;
        chk("t1_req_drained", req, 0);
        chk("t1_no_st_inflight", no_st, 0);
        ack = 1'b1; tick(); ack = 1'b0; #1;
        chk("t1_empty", empty, 1);

        // 2 and 3: same stores into merging and non-merging instances
        n_rst = 1'b0;
        push(56'h1000, 64'h11223344, 8'h0F);
        push(56'h1000, 64'h55667788_00000000, 8'hF0);
        push(56'h1004, 64'h99AABBCC_00000000, 8'hF0);
        commit = 1'b1;
        tick(); tick(); tick();
        commit = 1'b0; #1;
        chk("t2_cq_cnt", u_dut.r_cq_cnt, 2);
        chk("t3_cq_cnt", u_nm.r_cq_cnt, 3);
        chk("t2_A_addr", maddr, 56'h1000);
        chk("t2_A_data", mdata, 64'h11223344);
        chk("t2_A_be", mbe, 8'h0F);
        tick();
        chk("t2_A_stable_be", mbe, 8'h0F);
        chk("t2_A_stable_req", req, 1);
        gnt = 1'b1; tick();
        chk("t2_B_addr", maddr, 56'h1000);
        chk("t2_B_be", mbe, 8'hF0);
        chk("t2_B_merged_data", mdata, 64'h99AABBCC_00000000);
        tick();
        gnt = 1'b0; #1;
        chk("t2_req_after_2", req, 0);
        ack = 1'b1; tick(); tick(); ack = 1'b0; #1;
        chk("t2_no_st", no_st, 1);

        n_gnt = 1'b1; #1;
        chk("t3_A_be", n_mbe, 8'h0F);
        chk("t3_A_data", n_mdata, 64'h11223344);
        tick();
        chk("t3_B_be", n_mbe, 8'hF0);
        chk("t3_B_data", n_mdata, 64'h55667788_00000000);
        tick();
        n_gnt = 1'b0; #1;
        chk("t3_req_full", n_req, 0);
        n_ack = 1'b1; tick();
        n_gnt = 1'b1; #1;
        chk("t3_C_req", n_req, 1);
        chk("t3_C_addr", n_maddr, 56'h1004);
        chk("t3_C_data", n_mdata, 64'h99AABBCC_00000000);
        tick();
        n_gnt = 1'b0; tick(); n_ack = 1'b0; #1;
        chk("t3_no_st", n_no_st, 1);
        n_rst = 1'b1;

        // 4: outstanding limit and gnt+ack in one cycle
        push(56'h3000, 64'hA, 8'hFF);
        push(56'h3008, 64'hB, 8'hFF);
        push(56'h3010, 64'hC, 8'hFF);
        commit = 1'b1; tick(); tick(); tick(); commit = 1'b0; #1;
        chk("t4_cq_cnt", u_dut.r_cq_cnt, 3);
        gnt = 1'b1; tick(); tick(); gnt = 1'b0; #1;
        chk("t4_req_limit", req, 0);
        chk("t4_out_2", u_dut.r_out, 2);
        ack = 1'b1; tick(); #1;
        chk("t4_req_again", req, 1);
        chk("t4_out_1", u_dut.r_out, 1);
        gnt = 1'b1; tick(); gnt = 1'b0; #1;
        chk("t4_gnt_ack_out", u_dut.r_out, 1);
        chk("t4_gnt_ack_pop", u_dut.r_cq_cnt, 0);
        tick(); ack = 1'b0; #1;
        chk("t4_no_st", no_st, 1);

        // 5: commit and flush in the same cycle
        push(56'h4000, 64'hD, 8'hFF);
        push(56'h4008, 64'hE, 8'hFF);
        push(56'h4010, 64'hF, 8'hFF);
        commit = 1'b1; flush = 1'b1; #1;
        chk("t5_commit_ready", commit_ready, 1);
        tick();
        commit = 1'b0; flush = 1'b0; #1;
        chk("t5_cq_cnt", u_dut.r_cq_cnt, 1);
        chk("t5_spec_cnt", u_dut.r_spec_cnt, 0);
        chk("t5_head_addr", maddr, 56'h4000);
        chk("t5_commit_ready_0", commit_ready, 0);
        chk("t5_no_st_q", no_st, 0);
        gnt = 1'b1; tick(); gnt = 1'b0; #1;
        chk("t5_no_st_inflight", no_st, 0);
        ack = 1'b1; tick(); ack = 1'b0; #1;
        chk("t5_no_st_done", no_st, 1);
        chk("t5_empty", empty, 1);

        // 6: page-offset alias check
        push(56'h5238, 64'h1, 8'hFF);
        poff = 12'h23C; #1;
        chk("t6_match_spec", match, 1);
        commit = 1'b1; tick(); commit = 1'b0; #1;
        chk("t6_match_commit", match, 1);
        poff = 12'h240; #1;
        chk("t6_nomatch", match, 0);
        valid = 1'b1; paddr = 56'h7240; #1;
        chk("t6_match_incoming", match, 1);
        valid = 1'b0;
        gnt = 1'b1; tick(); gnt = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0;
        poff = 12'h23C; #1;
        chk("t6_empty", empty, 1);
        chk("t6_match_gone", match, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
